// File: rtl/pulse_period_checker.sv
// Measures clk cycles between rising edges of in_pulse, compares each period
// against EXPECTED, declares lock after LOCK_N consecutive matches and flags timeouts.
module pulse_period_checker #(
    parameter int unsigned PW       = 8,
    parameter int unsigned EXPECTED = 16,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned LOCK_N   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_pulse,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          match,
    output logic          mismatch,
    output logic          timeout,
    output logic          locked
);

    localparam logic [PW-1:0] LP_EXPECTED = PW'(EXPECTED);
    localparam logic [PW-1:0] LP_TIMEOUT  = PW'(TIMEOUT);
    localparam logic [PW-1:0] LP_ONE      = PW'(1);
    localparam logic [3:0]    LP_LOCK_N   = 4'(LOCK_N);

    typedef enum logic {
        ST_WAIT_FIRST,
        ST_MEASURE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_prev;
    logic [PW-1:0] r_cyc, w_cyc_nxt;
    logic [PW-1:0] r_period, w_period_nxt;
    logic [3:0]    r_match_cnt, w_match_cnt_nxt, w_match_cnt_inc;
    logic          r_valid, w_valid_nxt;
    logic          r_match, w_match_nxt;
    logic          r_mismatch, w_mismatch_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_locked, w_locked_nxt;
    logic          w_edge;

    assign w_edge = in_pulse & ~r_prev;

    // Saturating match count; reaching LOCK_N sets lock in the same update.
    assign w_match_cnt_inc = (r_match_cnt < LP_LOCK_N) ? r_match_cnt + 4'd1 : r_match_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WAIT_FIRST;
            r_prev      <= 1'b0;
            r_cyc       <= '0;
            r_period    <= '0;
            r_match_cnt <= '0;
            r_valid     <= 1'b0;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_timeout   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= in_pulse;
            r_cyc       <= w_cyc_nxt;
            r_period    <= w_period_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_match     <= w_match_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_timeout   <= w_timeout_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_period_nxt    = r_period;
        w_match_cnt_nxt = r_match_cnt;
        w_valid_nxt     = 1'b0;
        w_match_nxt     = 1'b0;
        w_mismatch_nxt  = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_locked_nxt    = r_locked;
        case (r_state)
            ST_WAIT_FIRST: begin
                if (w_edge) begin
                    w_cyc_nxt   = LP_ONE;
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // An edge landing exactly on cyc == TIMEOUT is a normal measurement.
                if (w_edge) begin
                    w_period_nxt = r_cyc;
                    w_cyc_nxt    = LP_ONE;
                    w_valid_nxt  = 1'b1;
                    if (r_cyc == LP_EXPECTED) begin
                        w_match_nxt     = 1'b1;
                        w_match_cnt_nxt = w_match_cnt_inc;
                        if (w_match_cnt_inc == LP_LOCK_N) begin
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_mismatch_nxt  = 1'b1;
                        w_match_cnt_nxt = '0;
                        w_locked_nxt    = 1'b0;
                    end
                end else if (r_cyc == LP_TIMEOUT) begin
                    w_timeout_nxt   = 1'b1;
                    w_state_nxt     = ST_WAIT_FIRST;
                    w_cyc_nxt       = '0;
                    w_match_cnt_nxt = '0;
                    w_locked_nxt    = 1'b0;
                end else begin
                    w_cyc_nxt = r_cyc + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_FIRST;
            end
        endcase
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign match        = r_match;
    assign mismatch     = r_mismatch;
    assign timeout      = r_timeout;
    assign locked       = r_locked;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker: default instance plus a TIMEOUT=20 instance.
module tb_pulse_period_checker;

    logic       clk;
    logic       reset;
    logic       in_a;
    logic       in_b;
    logic [7:0] period_a, period_b;
    logic       valid_a, match_a, mismatch_a, timeout_a, locked_a;
    logic       valid_b, match_b, mismatch_b, timeout_b, locked_b;

    int total;
    int bad;

    pulse_period_checker #(.PW(8), .EXPECTED(16), .TIMEOUT(255), .LOCK_N(3)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .in_pulse     (in_a),
        .period       (period_a),
        .period_valid (valid_a),
        .match        (match_a),
        .mismatch     (mismatch_a),
        .timeout      (timeout_a),
        .locked       (locked_a)
    );

    pulse_period_checker #(.PW(8), .EXPECTED(16), .TIMEOUT(20), .LOCK_N(3)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .in_pulse     (in_b),
        .period       (period_b),
        .period_valid (valid_b),
        .match        (match_b),
        .mismatch     (mismatch_b),
        .timeout      (timeout_b),
        .locked       (locked_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive for the next posedge; return at the following negedge with outputs settled.
    task automatic step_a(input logic p);
        in_a = p;
        @(negedge clk);
    endtask

    task automatic step_b(input logic p);
        in_b = p;
        @(negedge clk);
    endtask

    task automatic zeros_a(input int n);
        for (int i = 0; i < n; i++) step_a(1'b0);
    endtask

    task automatic check_a_edge(input string tag, input int per, input int m, input int lk);
        check({tag, "_valid"}, int'(valid_a), 1);
        check({tag, "_period"}, int'(period_a), per);
        check({tag, "_match"}, int'(match_a), m);
        check({tag, "_mismatch"}, int'(mismatch_a), 1 - m);
        check({tag, "_timeout"}, int'(timeout_a), 0);
        check({tag, "_locked"}, int'(locked_a), lk);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_period"}, int'(period_a), 0);
        check({tag, "_valid"}, int'(valid_a), 0);
        check({tag, "_match"}, int'(match_a), 0);
        check({tag, "_mismatch"}, int'(mismatch_a), 0);
        check({tag, "_timeout"}, int'(timeout_a), 0);
        check({tag, "_locked"}, int'(locked_a), 0);
    endtask

    initial begin
        int cnt;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        in_a  = 1'b0;
        in_b  = 1'b0;
        #1;
        check_a_zero("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Steady 16-clock train: first edge silent, lock on the third match.
        step_a(1'b1);
        check("first_edge_valid", int'(valid_a), 0);
        for (int k = 1; k <= 5; k++) begin
            step_a(1'b0);
            check($sformatf("strobe_drop%0d", k), int'(valid_a), 0);
            zeros_a(14);
            step_a(1'b1);
            check_a_edge($sformatf("lock%0d", k), 16, 1, (k >= 3) ? 1 : 0);
        end

        // One short interval breaks lock, then re-lock.
        zeros_a(14);
        step_a(1'b1);
        check_a_edge("short", 15, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            zeros_a(15);
            step_a(1'b1);
            check_a_edge($sformatf("relock%0d", k), 16, 1, (k == 3) ? 1 : 0);
        end

        // Lost pulse train: timeout exactly 255 clocks after the last edge.
        cnt = 0;
        for (int n = 1; n <= 254; n++) begin
            step_a(1'b0);
            if (timeout_a || valid_a) cnt++;
        end
        check("to_early", cnt, 0);
        step_a(1'b0);
        check("to_strobe", int'(timeout_a), 1);
        check("to_locked", int'(locked_a), 0);
        check("to_valid", int'(valid_a), 0);
        check("to_period_held", int'(period_a), 16);
        step_a(1'b0);
        check("to_one_cycle", int'(timeout_a), 0);
        step_a(1'b1);
        check("reentry_valid", int'(valid_a), 0);

        // Level held high yields a single edge.
        zeros_a(15);
        step_a(1'b1);
        check_a_edge("hold_rise", 16, 1, 0);
        cnt = 0;
        for (int n = 0; n < 39; n++) begin
            step_a(1'b1);
            if (valid_a) cnt++;
        end
        check("hold_no_dup", cnt, 0);
        zeros_a(8);
        step_a(1'b1);
        check_a_edge("hold_next", 48, 0, 0);

        // Async reset mid-interval while locked.
        for (int k = 1; k <= 3; k++) begin
            zeros_a(15);
            step_a(1'b1);
            check_a_edge($sformatf("prerst%0d", k), 16, 1, (k == 3) ? 1 : 0);
        end
        zeros_a(7);
        #2 reset = 1'b1;
        #1;
        check_a_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step_a(1'b1);
        check("post_rst_first", int'(valid_a), 0);
        zeros_a(15);
        step_a(1'b1);
        check_a_edge("post_rst", 16, 1, 0);
        in_a = 1'b0;

        // TIMEOUT=20 instance: edge on cyc == TIMEOUT wins, one clock later times out.
        cnt = 0;
        step_b(1'b1);
        check("b_first_valid", int'(valid_b), 0);
        for (int k = 1; k <= 2; k++) begin
            for (int n = 0; n < 19; n++) begin
                step_b(1'b0);
                if (timeout_b) cnt++;
            end
            step_b(1'b1);
            check($sformatf("b_edge%0d_valid", k), int'(valid_b), 1);
            check($sformatf("b_edge%0d_period", k), int'(period_b), 20);
            check($sformatf("b_edge%0d_mismatch", k), int'(mismatch_b), 1);
            check($sformatf("b_edge%0d_match", k), int'(match_b), 0);
            check($sformatf("b_edge%0d_timeout", k), int'(timeout_b), 0);
        end
        for (int n = 0; n < 19; n++) begin
            step_b(1'b0);
            if (timeout_b) cnt++;
        end
        check("b_no_early_timeout", cnt, 0);
        step_b(1'b0);
        check("b_timeout", int'(timeout_b), 1);
        check("b_timeout_valid", int'(valid_b), 0);
        check("b_timeout_locked", int'(locked_b), 0);
        step_b(1'b0);
        check("b_timeout_one_cycle", int'(timeout_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
